// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the two-master CPU memory bus arbiter.
// Optional round-robin arbitration is enabled by defining MIPS_BUS_ARB_RR_EN.
package mips_bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // One-hot owner vector for a given arbiter state.
  function automatic logic [1:0] grant_of(input arb_state_t st);
    logic [1:0] g;
    case (st)
      GNT0:    g = GRANT_M0;
      GNT1:    g = GRANT_M1;
      default: g = GRANT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mips_bus_arb_sel.sv
// Combinational winner selection between two bus masters.
// With MIPS_BUS_ARB_RR_EN a tie goes to the master that did not complete last.
module mips_bus_arb_sel (
  input  logic req0,
  input  logic req1,
`ifdef MIPS_BUS_ARB_RR_EN
  input  logic rr_ptr,
`endif
  output logic any_req,
  output logic win1
);

  // Pick the winning master from this cycle's requests.
  always_comb begin
    any_req = req0 | req1;
    win1    = 1'b0;
    if (req0 && req1) begin
`ifdef MIPS_BUS_ARB_RR_EN
      win1 = ~rr_ptr;
`else
      win1 = 1'b0;
`endif
    end else begin
      win1 = req1;
    end
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Two-master to one-slave arbiter for the waitrequest-stalled CPU memory bus.
// Fixed priority to master 0 by default; MIPS_BUS_ARB_RR_EN selects round-robin.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_write,
  input  logic                m0_read,
  output logic                m0_waitrequest,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic [DATA_W-1:0]   m0_readdata,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_write,
  input  logic                m1_read,
  output logic                m1_waitrequest,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic [ADDR_W-1:0]   s_address,
  output logic                s_write,
  output logic                s_read,
  input  logic                s_waitrequest,
  output logic [DATA_W-1:0]   s_writedata,
  output logic [DATA_W/8-1:0] s_byteenable,
  input  logic [DATA_W-1:0]   s_readdata,
  output logic [1:0]          grant
);

  arb_state_t state_r;
  logic [1:0] grant_r;
  logic       req0_s;
  logic       req1_s;
  logic       cur_req_s;
  logic       comp_s;
  logic       hold_s;
  logic       any_req_s;
  logic       win1_s;

  assign req0_s = m0_read | m0_write;
  assign req1_s = m1_read | m1_write;

  // Route the granted master onto the slave port; everyone else is stalled.
  always_comb begin
    s_address      = {ADDR_W{1'b0}};
    s_write        = 1'b0;
    s_read         = 1'b0;
    s_writedata    = {DATA_W{1'b0}};
    s_byteenable   = {(DATA_W/8){1'b0}};
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    cur_req_s      = 1'b0;
    case (state_r)
      GNT0: begin
        s_address      = m0_address;
        s_write        = m0_write;
        s_read         = m0_read;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
        cur_req_s      = req0_s;
      end
      GNT1: begin
        s_address      = m1_address;
        s_write        = m1_write;
        s_read         = m1_read;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
        cur_req_s      = req1_s;
      end
      default: begin
        cur_req_s      = 1'b0;
      end
    endcase
  end

  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;
  assign grant       = grant_r;

  assign comp_s = (state_r != IDLE) && cur_req_s && !s_waitrequest;
  assign hold_s = (state_r != IDLE) && cur_req_s && s_waitrequest;

`ifdef MIPS_BUS_ARB_RR_EN
  logic rr_ptr_r;
  logic rr_eff_s;

  // A completing master already counts as "last served" for the tie-break this cycle.
  assign rr_eff_s = comp_s ? (state_r == GNT1) : rr_ptr_r;

  mips_bus_arb_sel u_sel (
    .req0    (req0_s),
    .req1    (req1_s),
    .rr_ptr  (rr_eff_s),
    .any_req (any_req_s),
    .win1    (win1_s)
  );

  // Round-robin pointer: remembers which master completed most recently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_r <= 1'b0;
    end else if (comp_s) begin
      rr_ptr_r <= (state_r == GNT1);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`else
  mips_bus_arb_sel u_sel (
    .req0    (req0_s),
    .req1    (req1_s),
    .any_req (any_req_s),
    .win1    (win1_s)
  );
`endif

  // Ownership FSM: a grant is held until its transaction completes or is withdrawn.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      grant_r <= GRANT_NONE;
    end else if (hold_s) begin
      state_r <= state_r;
      grant_r <= grant_r;
    end else if (any_req_s) begin
      state_r <= win1_s ? GNT1 : GNT0;
      grant_r <= grant_of(win1_s ? GNT1 : GNT0);
    end else begin
      state_r <= IDLE;
      grant_r <= GRANT_NONE;
    end
  end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: directed bring-up cases, then random
// two-master traffic scored against an ownership/memory reference model.
module tb_mips_bus_arbiter;

  localparam int N_TXN = 24;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
    logic [3:0]  be;
  } txn_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_address   [2];
  logic        m_write     [2];
  logic        m_read      [2];
  logic        m_waitrequest [2];
  logic [31:0] m_writedata [2];
  logic [3:0]  m_byteenable [2];
  logic [31:0] m_readdata  [2];
  logic [31:0] s_address;
  logic        s_write;
  logic        s_read;
  logic        s_waitrequest;
  logic [31:0] s_writedata;
  logic [3:0]  s_byteenable;
  logic [31:0] s_readdata;
  logic [1:0]  grant;

  logic [31:0] ram [32] = '{default: 32'h0};
  logic [31:0] rd_force;
  logic        rd_force_en;

  int checks = 0;
  int errors = 0;

  txn_t q0[$];
  txn_t q1[$];
  logic mon_en = 1'b0;
  int   owner;
  int   last_done;
  logic [31:0] gold [32];

  always #5 clk = ~clk;

  mips_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m_address[0]), .m0_write(m_write[0]), .m0_read(m_read[0]),
    .m0_waitrequest(m_waitrequest[0]), .m0_writedata(m_writedata[0]),
    .m0_byteenable(m_byteenable[0]), .m0_readdata(m_readdata[0]),
    .m1_address(m_address[1]), .m1_write(m_write[1]), .m1_read(m_read[1]),
    .m1_waitrequest(m_waitrequest[1]), .m1_writedata(m_writedata[1]),
    .m1_byteenable(m_byteenable[1]), .m1_readdata(m_readdata[1]),
    .s_address(s_address), .s_write(s_write), .s_read(s_read),
    .s_waitrequest(s_waitrequest), .s_writedata(s_writedata),
    .s_byteenable(s_byteenable), .s_readdata(s_readdata), .grant(grant)
  );

  // Simple RAM slave; read data can be overridden for directed cases.
  always_comb s_readdata = rd_force_en ? rd_force : ram[s_address[6:2]];

  always @(posedge clk) begin
    if (s_write && !s_waitrequest) begin
      for (int b = 0; b < 4; b++)
        if (s_byteenable[b]) ram[s_address[6:2]][8*b +: 8] <= s_writedata[8*b +: 8];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model / monitor: who should own the bus, and what each completion returns.
  always @(negedge clk) begin
    int k;
    logic [1:0] req;
    logic comp;
    txn_t t;
    if (!mon_en) begin
      owner = 0;
      last_done = 0;
      for (int i = 0; i < 32; i++) gold[i] = 32'h0;
    end else begin
      chk("grant", {30'd0, grant}, (owner == 1) ? 32'd1 : (owner == 2) ? 32'd2 : 32'd0);
      req[0] = m_read[0] | m_write[0];
      req[1] = m_read[1] | m_write[1];
      comp = 1'b0;
      if (owner == 0) begin
        chk("idle_bus", {28'd0, s_read, s_write, m_waitrequest[0], m_waitrequest[1]}, 32'h3);
      end else begin
        k = owner - 1;
        chk("s_address_mux", s_address, m_address[k]);
        chk("s_rw_mux", {30'd0, s_read, s_write}, {30'd0, m_read[k], m_write[k]});
        chk("own_wait", {31'd0, m_waitrequest[k]}, {31'd0, s_waitrequest});
        chk("other_wait", {31'd0, m_waitrequest[1-k]}, 32'd1);
        comp = req[k] && !s_waitrequest;
        if (comp) begin
          if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            chk("unexpected_completion", k, 32'hFFFF_FFFF);
          end else begin
            t = (k == 0) ? q0.pop_front() : q1.pop_front();
            chk("txn_addr", s_address, t.addr);
            chk("txn_write", {31'd0, s_write}, {31'd0, t.wr});
            if (t.wr) begin
              chk("txn_wdata", s_writedata, t.data);
              chk("txn_be", {28'd0, s_byteenable}, {28'd0, t.be});
              for (int b = 0; b < 4; b++)
                if (t.be[b]) gold[t.addr[6:2]][8*b +: 8] = t.data[8*b +: 8];
            end else begin
              chk("txn_rdata", m_readdata[k], gold[t.addr[6:2]]);
            end
          end
          last_done = k;
        end
      end
      // Next owner: keep a stalled grant, otherwise pick from current requests.
      if (owner != 0 && req[owner-1] && s_waitrequest) owner = owner;
      else if (req == 2'b00) owner = 0;
      else if (req == 2'b01) owner = 1;
      else if (req == 2'b10) owner = 2;
      else begin
`ifdef MIPS_BUS_ARB_RR_EN
        owner = (last_done == 0) ? 2 : 1;
`else
        owner = 1;
`endif
      end
    end
  end

  task automatic wait_own(input int k, input string name);
    int n;
    n = 0;
    while (!(grant == (k == 0 ? 2'b01 : 2'b10) && !m_waitrequest[k]) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, n < 20, 32'd1);
  endtask

  initial begin
    int   cnt [2];
    int   gap [2];
    logic act [2];
    logic done [2];
    txn_t t;

    reset = 1'b0;
    s_waitrequest = 1'b0;
    rd_force = 32'h0;
    rd_force_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_address[i] = 32'h0; m_write[i] = 1'b0; m_read[i] = 1'b0;
      m_writedata[i] = 32'h0; m_byteenable[i] = 4'h0;
    end

    // Reset held with m0 requesting.
    m_read[0] = 1'b1;
    m_address[0] = 32'hBFC0_0000;
    s_waitrequest = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_s_read", {31'd0, s_read}, 32'd0);
    chk("rst_waits", {30'd0, m_waitrequest[0], m_waitrequest[1]}, 32'h3);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_grant", {30'd0, grant}, 32'd1);
    chk("rel_s_address", s_address, 32'hBFC0_0000);
    chk("rel_s_read", {31'd0, s_read}, 32'd1);

    // Boot fetch with three stall cycles.
    repeat (2) begin
      @(negedge clk);
      chk("stall_waits", {30'd0, m_waitrequest[0], m_waitrequest[1]}, 32'h3);
    end
    s_waitrequest = 1'b0;
    rd_force = 32'h3C03_BFC0;
    rd_force_en = 1'b1;
    @(negedge clk);
    chk("boot_rdata", m_readdata[0], 32'h3C03_BFC0);
    chk("boot_waits", {30'd0, m_waitrequest[0], m_waitrequest[1]}, 32'h1);
    @(posedge clk); #1;
    m_read[0] = 1'b0;
    rd_force_en = 1'b0;
    repeat (2) @(posedge clk); #1;

    // m1 partial write, then m0 reads it back.
    m_write[1] = 1'b1; m_address[1] = 32'h10;
    m_writedata[1] = 32'hDEAD_BEEF; m_byteenable[1] = 4'b0011;
    @(negedge clk);
    chk("req_latency", {30'd0, grant}, 32'd0);
    @(negedge clk);
    chk("m1_grant", {30'd0, grant}, 32'd2);
    chk("m1_s_addr", s_address, 32'h10);
    chk("m1_s_wdata", s_writedata, 32'hDEAD_BEEF);
    chk("m1_s_be", {28'd0, s_byteenable}, 32'h3);
    chk("m1_s_write", {31'd0, s_write}, 32'd1);
    @(posedge clk); #1;
    m_write[1] = 1'b0;
    m_read[0] = 1'b1; m_address[0] = 32'h10;
    @(negedge clk);
    wait_own(0, "rb_wait");
    chk("rb_rdata", m_readdata[0], 32'h0000_BEEF);
    @(posedge clk); #1;
    m_read[0] = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Reset in the middle of a stalled m1 write.
    s_waitrequest = 1'b1;
    m_write[1] = 1'b1; m_address[1] = 32'h20; m_writedata[1] = 32'h1234_5678;
    m_byteenable[1] = 4'hF;
    repeat (3) @(negedge clk);
    chk("mid_grant", {30'd0, grant}, 32'd2);
    chk("mid_s_write", {31'd0, s_write}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_s_write", {31'd0, s_write}, 32'd0);
    chk("async_grant", {30'd0, grant}, 32'd0);
    chk("async_waits", {30'd0, m_waitrequest[0], m_waitrequest[1]}, 32'h3);
    m_write[1] = 1'b0;
    m_read[0] = 1'b1; m_address[0] = 32'h10;
    s_waitrequest = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("restart_grant", {30'd0, grant}, 32'd1);
    chk("restart_rdata", m_readdata[0], 32'h0000_BEEF);
    chk("aborted_write", ram[8], 32'h0);
    @(posedge clk); #1;
    m_read[0] = 1'b0;

    // Fresh reset so the model and the rr pointer start aligned.
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    for (int i = 0; i < 2; i++) begin
      cnt[i] = 0; gap[i] = 0; act[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (cnt[0] >= N_TXN && cnt[1] >= N_TXN && !act[0] && !act[1]) break;
      @(negedge clk);
      for (int i = 0; i < 2; i++) done[i] = act[i] && !m_waitrequest[i];
      @(posedge clk); #1;
      s_waitrequest = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < 2; i++) begin
        if (done[i]) begin
          act[i] = 1'b0; m_read[i] = 1'b0; m_write[i] = 1'b0;
          cnt[i]++;
          gap[i] = $urandom_range(0, 2);
        end else if (act[i]) begin
          act[i] = 1'b1;
        end else if (gap[i] > 0) begin
          gap[i]--;
        end else if (cnt[i] < N_TXN) begin
          t.addr = 32'h40 + ($urandom_range(0, 15) << 2);
          t.wr   = $urandom_range(0, 1);
          t.data = $urandom;
          t.be   = 4'($urandom_range(1, 15));
          m_address[i] = t.addr; m_write[i] = t.wr; m_read[i] = ~t.wr;
          m_writedata[i] = t.data; m_byteenable[i] = t.be;
          act[i] = 1'b1;
          if (i == 0) q0.push_back(t); else q1.push_back(t);
        end else begin
          act[i] = 1'b0;
        end
      end
    end
    repeat (2) @(negedge clk);
    chk("m0_txn_count", cnt[0], N_TXN);
    chk("m1_txn_count", cnt[1], N_TXN);
    chk("q_drained", q0.size() + q1.size(), 32'd0);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
